// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - two-write/two-read register file with pending-write scoreboard
//
// Ports:
//   clk                     clock, all state updates on the rising edge
//   rst                     asynchronous active-high reset (registers and busy flags)
//   we0/waddr0/wdata0       write port 0 (ALU writeback)
//   we1/waddr1/wdata1       write port 1 (load writeback); wins on address collision
//   raddr1/raddr2           read addresses
//   rdata1/rdata2           combinational read data (optional same-cycle forwarding)
//   rbusy1/rbusy2           read register has an outstanding write not resolved this cycle
//   iss_valid/iss_rd        issue event, marks iss_rd as awaiting writeback
//   flush                   synchronous clear of all pending flags
//   busy_vec                registered pending flags, bit n = register n

module regfile_sb #(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we0,
    input  logic [AW-1:0]   waddr0,
    input  logic [XLEN-1:0] wdata0,
    input  logic            we1,
    input  logic [AW-1:0]   waddr1,
    input  logic [XLEN-1:0] wdata1,
    input  logic [AW-1:0]   raddr1,
    input  logic [AW-1:0]   raddr2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2,
    output logic            rbusy1,
    output logic            rbusy2,
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_rd,
    input  logic            flush,
    output logic [NREG-1:0] busy_vec
);

    localparam bit ZR = (ZERO_REG != 0);
    localparam bit BP = (BYPASS != 0);

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    // A write (or issue) aimed at the hardwired zero register has no effect at all,
    // so it neither updates storage, nor forwards, nor touches the busy flags.
    logic we0_eff;
    logic we1_eff;
    logic iss_eff;

    assign we0_eff = we0 && !(ZR && (waddr0 == '0));
    assign we1_eff = we1 && !(ZR && (waddr1 == '0));
    assign iss_eff = iss_valid && !(ZR && (iss_rd == '0));

    // Storage: port 1 is written after port 0 so it wins a same-address collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (we0_eff) begin
                regs[waddr0] <= wdata0;
            end
            if (we1_eff) begin
                regs[waddr1] <= wdata1;
            end
        end
    end

    // Scoreboard next state. Writeback clears, then issue sets (an issue racing a
    // writeback to the same register belongs to a newer instruction, so it must stay
    // busy), then flush overrides everything.
    always_comb begin
        busy_d = busy_q;
        if (we0_eff) begin
            busy_d[waddr0] = 1'b0;
        end
        if (we1_eff) begin
            busy_d[waddr1] = 1'b0;
        end
        if (iss_eff) begin
            busy_d[iss_rd] = 1'b1;
        end
        if (flush) begin
            busy_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

    // Read ports. Both share one description; each sees its own address.
    logic [AW-1:0] raddr_p [2];
    assign raddr_p[0] = raddr1;
    assign raddr_p[1] = raddr2;

    for (genvar p = 0; p < 2; p++) begin : g_read
        logic            hit0;
        logic            hit1;
        logic            is_zero;
        logic [XLEN-1:0] rd;
        logic            rb;

        assign hit0    = we0_eff && (waddr0 == raddr_p[p]);
        assign hit1    = we1_eff && (waddr1 == raddr_p[p]);
        assign is_zero = ZR && (raddr_p[p] == '0);

        always_comb begin
            rd = regs[raddr_p[p]];
            if (BP) begin
                if (hit1) begin
                    rd = wdata1;
                end else if (hit0) begin
                    rd = wdata0;
                end
            end
            // Reset gating also covers the forwarding path, whose inputs are live.
            if (rst || is_zero) begin
                rd = '0;
            end
        end

        // A write landing this cycle resolves the hazard regardless of forwarding:
        // without bypass the consumer simply reads the result a cycle later.
        assign rb = !rst && !is_zero && busy_q[raddr_p[p]] && !hit0 && !hit1;
    end

    assign rdata1 = g_read[0].rd;
    assign rdata2 = g_read[1].rd;
    assign rbusy1 = g_read[0].rb;
    assign rbusy2 = g_read[1].rb;

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - scoreboard bench for regfile_sb (default config and XLEN=64/NREG=16/no zero reg/no bypass)

module tb_regfile_sb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        we0, we1, iss_valid, flush;
    logic [4:0]  waddr0, waddr1, raddr1, raddr2, iss_rd;
    logic [63:0] wdata0, wdata1;

    logic [31:0] rdata1_a, rdata2_a, busy_vec_a;
    logic        rbusy1_a, rbusy2_a;
    logic [63:0] rdata1_b, rdata2_b;
    logic [15:0] busy_vec_b;
    logic        rbusy1_b, rbusy2_b;

    // Config 0: defaults (XLEN 32, NREG 32, zero reg, bypass)
    regfile_sb u_a (
        .clk(clk), .rst(rst),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0[31:0]),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1[31:0]),
        .raddr1(raddr1), .raddr2(raddr2),
        .rdata1(rdata1_a), .rdata2(rdata2_a),
        .rbusy1(rbusy1_a), .rbusy2(rbusy2_a),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .flush(flush),
        .busy_vec(busy_vec_a)
    );

    // Config 1: XLEN 64, NREG 16, no zero reg, no bypass
    regfile_sb #(.XLEN(64), .NREG(16), .ZERO_REG(0), .BYPASS(0)) u_b (
        .clk(clk), .rst(rst),
        .we0(we0), .waddr0(waddr0[3:0]), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1[3:0]), .wdata1(wdata1),
        .raddr1(raddr1[3:0]), .raddr2(raddr2[3:0]),
        .rdata1(rdata1_b), .rdata2(rdata2_b),
        .rbusy1(rbusy1_b), .rbusy2(rbusy2_b),
        .iss_valid(iss_valid), .iss_rd(iss_rd[3:0]), .flush(flush),
        .busy_vec(busy_vec_b)
    );

    typedef struct {
        logic [63:0] rd1_a, rd2_a, bv_a;
        logic        rb1_a, rb2_a;
        logic [63:0] rd1_b, rd2_b, bv_b;
        logic        rb1_b, rb2_b;
    } exp_t;

    exp_t q[$];
    int tests_run = 0;
    int tests_failed = 0;

    // Reference model: architectural register contents and pending flags per config.
    logic [63:0] mem  [2][32];
    bit          busy [2][32];

    function automatic int amap(int c, logic [4:0] a);
        return (c == 0) ? int'(a) : int'(a[3:0]);
    endfunction

    function automatic logic [63:0] dmap(int c, logic [63:0] d);
        return (c == 0) ? (d & 64'h0000_0000_FFFF_FFFF) : d;
    endfunction

    function automatic int nreg(int c);
        return (c == 0) ? 32 : 16;
    endfunction

    // Config 0 has the zero register and forwarding; config 1 has neither.
    function automatic bit wr_ok(int c, logic we, logic [4:0] a);
        return we && !(c == 0 && amap(c, a) == 0);
    endfunction

    function automatic logic [63:0] exp_read(int c, logic [4:0] ra);
        int r = amap(c, ra);
        if (rst) return 64'd0;
        if (c == 0 && r == 0) return 64'd0;
        if (c == 0) begin
            if (wr_ok(c, we1, waddr1) && amap(c, waddr1) == r) return dmap(c, wdata1);
            if (wr_ok(c, we0, waddr0) && amap(c, waddr0) == r) return dmap(c, wdata0);
        end
        return mem[c][r];
    endfunction

    function automatic logic exp_rbusy(int c, logic [4:0] ra);
        int r = amap(c, ra);
        if (rst) return 1'b0;
        if (c == 0 && r == 0) return 1'b0;
        if (wr_ok(c, we0, waddr0) && amap(c, waddr0) == r) return 1'b0;
        if (wr_ok(c, we1, waddr1) && amap(c, waddr1) == r) return 1'b0;
        return busy[c][r];
    endfunction

    function automatic logic [63:0] exp_vec(int c);
        logic [63:0] v = 64'd0;
        for (int i = 0; i < nreg(c); i++) v[i] = busy[c][i];
        return v;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 2; c++)
            for (int i = 0; i < 32; i++) begin
                mem[c][i]  = 64'd0;
                busy[c][i] = 1'b0;
            end
    endtask

    task automatic model_edge();
        for (int c = 0; c < 2; c++) begin
            if (wr_ok(c, we0, waddr0)) mem[c][amap(c, waddr0)] = dmap(c, wdata0);
            if (wr_ok(c, we1, waddr1)) mem[c][amap(c, waddr1)] = dmap(c, wdata1);
            if (flush) begin
                for (int i = 0; i < 32; i++) busy[c][i] = 1'b0;
            end else begin
                if (wr_ok(c, we0, waddr0)) busy[c][amap(c, waddr0)] = 1'b0;
                if (wr_ok(c, we1, waddr1)) busy[c][amap(c, waddr1)] = 1'b0;
                if (iss_valid && !(c == 0 && amap(c, iss_rd) == 0)) busy[c][amap(c, iss_rd)] = 1'b1;
            end
        end
    endtask

    task automatic begin_cycle();
        @(negedge clk);
        we0 = 0; we1 = 0; iss_valid = 0; flush = 0;
        waddr0 = 0; waddr1 = 0; raddr1 = 0; raddr2 = 0; iss_rd = 0;
        wdata0 = 0; wdata1 = 0;
    endtask

    task automatic randomize_inputs();
        we0 = 1'($urandom_range(0, 1));
        we1 = 1'($urandom_range(0, 1));
        iss_valid = 1'($urandom_range(0, 1));
        flush = ($urandom_range(0, 15) == 0);
        waddr0 = 5'($urandom); waddr1 = 5'($urandom);
        raddr1 = 5'($urandom); raddr2 = 5'($urandom);
        iss_rd = 5'($urandom);
        wdata0 = {$urandom, $urandom}; wdata1 = {$urandom, $urandom};
    endtask

    // Record what the outputs must show this cycle, then advance the model past the edge.
    task automatic end_cycle();
        exp_t e;
        e.rd1_a = exp_read(0, raddr1);  e.rd2_a = exp_read(0, raddr2);
        e.rb1_a = exp_rbusy(0, raddr1); e.rb2_a = exp_rbusy(0, raddr2);
        e.bv_a  = exp_vec(0);
        e.rd1_b = exp_read(1, raddr1);  e.rd2_b = exp_read(1, raddr2);
        e.rb1_b = exp_rbusy(1, raddr1); e.rb2_b = exp_rbusy(1, raddr2);
        e.bv_b  = exp_vec(1);
        q.push_back(e);
        if (!rst) model_edge();
    endtask

    // Reset asserted between edges with live write/issue traffic, held, then released.
    task automatic mid_cycle_reset(int hold);
        begin_cycle();
        randomize_inputs();
        #1 rst = 1'b1;
        model_reset();
        end_cycle();
        for (int i = 0; i < hold; i++) begin
            begin_cycle();
            randomize_inputs();
            end_cycle();
        end
        begin_cycle();
        rst = 1'b0;
        end_cycle();
    endtask

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Monitor: outputs are combinational/registered every cycle, sampled mid low phase.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("rdata1_a", {32'd0, rdata1_a}, e.rd1_a);
                chk("rdata2_a", {32'd0, rdata2_a}, e.rd2_a);
                chk("rbusy1_a", {63'd0, rbusy1_a}, {63'd0, e.rb1_a});
                chk("rbusy2_a", {63'd0, rbusy2_a}, {63'd0, e.rb2_a});
                chk("busy_vec_a", {32'd0, busy_vec_a}, e.bv_a);
                chk("rdata1_b", rdata1_b, e.rd1_b);
                chk("rdata2_b", rdata2_b, e.rd2_b);
                chk("rbusy1_b", {63'd0, rbusy1_b}, {63'd0, e.rb1_b});
                chk("rbusy2_b", {63'd0, rbusy2_b}, {63'd0, e.rb2_b});
                chk("busy_vec_b", {48'd0, busy_vec_b}, e.bv_b);
            end
        end
    end

    initial begin
        #2_000_000;
        tests_run++;
        tests_failed++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        rst = 1'b1;
        we0 = 0; we1 = 0; iss_valid = 0; flush = 0;
        waddr0 = 0; waddr1 = 0; raddr1 = 0; raddr2 = 0; iss_rd = 0;
        wdata0 = 0; wdata1 = 0;
        model_reset();
        repeat (2) begin begin_cycle(); randomize_inputs(); end_cycle(); end

        // Basic write then read back, plus the zero register
        begin_cycle(); rst = 1'b0;
        we0 = 1; waddr0 = 5; wdata0 = 64'hDEAD_BEEF; end_cycle();
        begin_cycle(); raddr1 = 5; raddr2 = 0; end_cycle();

        // Dual write collision on 7 with a same-cycle read, then read back
        begin_cycle(); we0 = 1; waddr0 = 7; wdata0 = 64'h11;
        we1 = 1; waddr1 = 7; wdata1 = 64'h22; raddr1 = 7; end_cycle();
        begin_cycle(); raddr1 = 7; end_cycle();

        // Issue 9, observe pending, resolve with a load writeback
        begin_cycle(); iss_valid = 1; iss_rd = 9; end_cycle();
        begin_cycle(); raddr1 = 9; end_cycle();
        begin_cycle(); raddr1 = 9; we1 = 1; waddr1 = 9; wdata1 = 64'h99; end_cycle();
        begin_cycle(); raddr1 = 9; end_cycle();

        // Issue racing writeback on 3, then flush overriding an issue of 4
        begin_cycle(); iss_valid = 1; iss_rd = 3; we0 = 1; waddr0 = 3; wdata0 = 64'h33; raddr1 = 3; end_cycle();
        begin_cycle(); flush = 1; iss_valid = 1; iss_rd = 4; raddr1 = 3; end_cycle();
        begin_cycle(); raddr1 = 3; raddr2 = 4; end_cycle();

        // Write and issue to register 0
        begin_cycle(); we0 = 1; waddr0 = 0; wdata0 = 64'hFFFF_FFFF; iss_valid = 1; iss_rd = 0; end_cycle();
        begin_cycle(); raddr1 = 0; end_cycle();

        // Random traffic with an occasional asynchronous reset
        for (int n = 0; n < 600; n++) begin
            if (n == 300) mid_cycle_reset(2);
            begin_cycle();
            randomize_inputs();
            end_cycle();
        end

        // Load up busy flags, then reset mid-cycle
        for (int i = 1; i < 16; i++) begin
            begin_cycle(); iss_valid = 1; iss_rd = 5'(i);
            we0 = 1; waddr0 = 5'(i + 16); wdata0 = {$urandom, $urandom};
            end_cycle();
        end
        mid_cycle_reset(1);
        repeat (3) begin begin_cycle(); randomize_inputs(); end_cycle(); end

        repeat (3) @(negedge clk);
        #5;
        chk("scoreboard_drained", 64'(q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL provide parameter XLEN, default 32, data width in bits.
REQ-002 SHALL provide parameter NREG, default 32, register count, power of two, 2 to 64.
REQ-003 SHALL provide parameter ZERO_REG, default 1; 1 = register 0 hardwired to zero.
REQ-004 SHALL provide parameter BYPASS, default 1; 1 = same-cycle write-to-read forwarding.
REQ-005 SHALL derive AW = log2(NREG) internally; AW SHALL NOT be a user parameter.
REQ-006 clk  input  1  clock; all state updates on the rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 we0, waddr0, wdata0  input  1/AW/XLEN  write port 0: ALU writeback.
REQ-009 we1, waddr1, wdata1  input  1/AW/XLEN  write port 1: load writeback.
REQ-010 raddr1, raddr2  input  AW  read addresses.
REQ-011 rdata1, rdata2  output  XLEN  combinational read data.
REQ-012 rbusy1, rbusy2  output  1  pending-write flag for raddr1/raddr2.
REQ-013 iss_valid, iss_rd  input  1/AW  issue event: marks iss_rd pending.
REQ-014 flush  input  1  synchronous clear of all pending flags.
REQ-015 busy_vec  output  NREG  registered pending flags, bit n = register n.

Function
REQ-016 A write on port p SHALL occur at the clock edge when we_p=1, except to address 0 when ZERO_REG=1.
REQ-017 Collision: we0=we1=1 with waddr0=waddr1 SHALL store wdata1; port 1 wins.
REQ-018 Read: rdata = stored value; address 0 SHALL read 0 when ZERO_REG=1, regardless of writes.
REQ-019 With BYPASS=1, a read matching a same-cycle enabled, non-suppressed write SHALL return that write's data, port 1 before port 0; with BYPASS=0 it SHALL return the pre-edge value.
REQ-020 Scoreboard: iss_valid=1 SHALL set busy_vec[iss_rd] at the next edge; iss_rd=0 SHALL be ignored when ZERO_REG=1.
REQ-021 An enabled write SHALL clear busy_vec[waddr] at the edge.
REQ-022 Simultaneous issue and write to the same register: set SHALL win; busy_vec bit stays 1.
REQ-023 flush=1 SHALL clear every busy_vec bit at the edge, overriding a same-cycle issue; register contents SHALL be unaffected.
REQ-024 rbusy = busy_vec[raddr] AND NOT (same-cycle enabled write to raddr); this SHALL hold for both BYPASS values.
REQ-025 rbusy SHALL be 0 for address 0 when ZERO_REG=1.
REQ-026 Issue to an already-busy register SHALL leave it busy; no count is kept, single outstanding write per register.
REQ-027 Write to a non-busy register SHALL be legal and SHALL update data; busy stays 0.
REQ-028 No additional latency: write visible to plain reads on the cycle after the edge.

Reset
REQ-029 rst=1 SHALL clear all registers to 0 and all busy_vec bits to 0 immediately, without waiting for clk.
REQ-030 During reset, rdata SHALL read 0 and rbusy SHALL read 0 for all addresses, bypass included (write inputs ignored).
REQ-031 Writes and issues presented while rst=1 SHALL be discarded; the first effective edge is the first rising clk after rst falls.

Verification
REQ-032 Reset, then we0=1 waddr0=5 wdata0=0xDEADBEEF; next cycle raddr1=5 -> rdata1=0xDEADBEEF; raddr2=0 -> 0.
REQ-033 BYPASS=1: same cycle we0=1 waddr0=7 wdata0=0x11 and we1=1 waddr1=7 wdata1=0x22, raddr1=7 -> rdata1=0x22 that cycle, 0x22 stored afterwards; repeat with BYPASS=0 -> old value that cycle.
REQ-034 Issue rd=9 -> busy_vec[9]=1, rbusy1=1 for raddr1=9; later we1=1 waddr1=9 -> rbusy1=0 in the write cycle, busy_vec[9]=0 after the edge.
REQ-035 Same cycle iss_rd=3 and we0 waddr0=3 -> busy_vec[3]=1 after the edge; then flush with iss_rd=4 -> busy_vec all 0.
REQ-036 we0 waddr0=0 wdata0=0xFFFFFFFF and issue rd=0 -> rdata=0, busy_vec[0]=0 (ZERO_REG=1); ZERO_REG=0 -> rdata=0xFFFFFFFF.
REQ-037 Assert rst asynchronously mid-cycle with registers and busy bits set -> all rdata, rbusy and busy_vec outputs 0 before the next clk edge; run with XLEN=64 and NREG=16 also.
